// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster geometry shared by the timing generator, sprite renderers and
// collision logic, plus a small window-compare helper.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows are half-open: [START, END)
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  function automatic logic in_window(input logic [9:0] val, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, val} >= lo) && ({1'b0, val} < hi);
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Board-clock divider producing a registered one-clk enable every DIV clocks.
module clk_enable_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] div_r;
  logic [CW-1:0] div_nxt_s;

  // Wrapping divider count
  always_comb begin
    div_nxt_s = div_r;
    if (div_r == LAST) begin
      div_nxt_s = ZERO;
    end else begin
      div_nxt_s = div_r + ONE;
    end
  end

  // en is registered from the next count so it is high exactly while div_r == LAST
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_r <= ZERO;
      en    <= 1'b0;
    end else begin
      div_r <= div_nxt_s;
      en    <= (div_nxt_s == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters with sync, blanking, line/frame strobes and a
// frame counter, all registered so they line up with the counters in the same clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: raster exceeds 10-bit counters or CLK_DIV < 1");
  end

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_nxt_s;
  logic [9:0] v_nxt_s;
  logic       hsync_nxt_s;
  logic       vsync_nxt_s;
  logic       video_nxt_s;
  logic       line_nxt_s;
  logic       frame_nxt_s;

  clk_enable_div #(.DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en)
  );

  // Next counter position and the outputs decoded from it
  always_comb begin
    h_nxt_s = h_counter;
    v_nxt_s = v_counter;
    if (pix_en) begin
      if (h_counter == H_LAST) begin
        h_nxt_s = 10'd0;
        if (v_counter == V_LAST) begin
          v_nxt_s = 10'd0;
        end else begin
          v_nxt_s = v_counter + 10'd1;
        end
      end else begin
        h_nxt_s = h_counter + 10'd1;
        v_nxt_s = v_counter;
      end
    end else begin
      h_nxt_s = h_counter;
      v_nxt_s = v_counter;
    end
    hsync_nxt_s = !in_window(h_nxt_s, HS_START, HS_END);
    vsync_nxt_s = !in_window(v_nxt_s, VS_START, VS_END);
    video_nxt_s = in_window(h_nxt_s, 11'd0, H_VIS_END) && in_window(v_nxt_s, 11'd0, V_VIS_END);
    line_nxt_s  = pix_en && (h_nxt_s == 10'd0);
    frame_nxt_s = line_nxt_s && (v_nxt_s == 10'd0);
  end

  // Decoded outputs only refresh on pixel steps, so the post-reset (0,0) pixel stays blanked
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_counter   <= 10'd0;
      v_counter   <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      h_counter  <= h_nxt_s;
      v_counter  <= v_nxt_s;
      line_tick  <= line_nxt_s;
      frame_tick <= frame_nxt_s;
      if (pix_en) begin
        hsync    <= hsync_nxt_s;
        vsync    <= vsync_nxt_s;
        video_on <= video_nxt_s;
      end
      if (frame_nxt_s) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
